// File: rtl/add_ppu_array_pkg.sv
// Shared widths, phase encoding and output saturation for the add PPU array.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package add_ppu_array_pkg;

  localparam int X_W        = 9;   // zero-point-corrected lane operand
  localparam int Y_W        = 8;   // unsigned lane result
  localparam int M_W        = 26;  // unsigned scale
  localparam int N_W        = 6;   // right-shift amount
  localparam int ACC_W      = 37;  // A*m1 + B*m2 without overflow
  localparam int BASE_DEPTH = 4;   // B beat to lane output register

  // Product of a signed operand and a zero-extended scale.
  localparam int PROD_W = X_W + M_W + 1;
  // Wide enough to hold the accumulator plus a rounding constant of 2^62,
  // so rounding stays exact for every shift amount up to 63.
  localparam int RND_W  = 65;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  // Clamp a signed value to the unsigned output range [0, 2^Y_W - 1].
  function automatic logic [Y_W-1:0] sat_u8(input logic signed [RND_W-1:0] v);
    logic [Y_W-1:0] r;
    if (v[RND_W-1])
      r = '0;
    else if (|v[RND_W-2:Y_W])
      r = '1;
    else
      r = v[Y_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/add_ppu_array_lane.sv
// One lane: Y = clamp(round_shift(A*m1 + B*m2, n) + Cz, 0, 255).
// Latency: 4 clocks from the B operand to o_y (stages are free-running).
// Backpressure: none; the final register only updates when i_out_en is high.
module add_ppu_lane
  import add_ppu_array_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_a_ld,
  input  logic                   i_out_en,
  input  logic signed [X_W-1:0]  i_x,
  input  logic        [M_W-1:0]  i_m1,
  input  logic        [M_W-1:0]  i_m2,
  input  logic        [N_W-1:0]  i_n,
  input  logic        [Y_W-1:0]  i_cz,
  output logic        [Y_W-1:0]  o_y
);

  logic signed [X_W-1:0]    r_a;
  logic signed [X_W-1:0]    r_a1, r_b1;
  logic        [M_W-1:0]    r_m1, r_m2;
  logic        [N_W-1:0]    r_n1, r_n2, r_n3;
  logic        [Y_W-1:0]    r_cz1, r_cz2, r_cz3;
  logic signed [PROD_W-1:0] r_p1, r_p2;
  logic signed [RND_W-1:0]  r_sum;
  logic        [Y_W-1:0]    r_y;

  logic signed [ACC_W-1:0]  w_s;
  logic signed [RND_W-1:0]  w_rnd;
  logic signed [RND_W-1:0]  w_t;
  logic signed [RND_W-1:0]  w_z;

  // Hold the A operand until its partner B beat arrives.
  always_ff @(posedge clk) begin
    if (i_a_ld)
      r_a <= i_x;
  end

  // Stage 1: pair A with B and sample the scales alongside the B beat.
  always_ff @(posedge clk) begin
    r_a1  <= r_a;
    r_b1  <= i_x;
    r_m1  <= i_m1;
    r_m2  <= i_m2;
    r_n1  <= i_n;
    r_cz1 <= i_cz;
  end

  // Stage 2: the two multiplies; scales are zero-extended to stay positive.
  always_ff @(posedge clk) begin
    r_p1  <= PROD_W'(r_a1) * PROD_W'($signed({1'b0, r_m1}));
    r_p2  <= PROD_W'(r_b1) * PROD_W'($signed({1'b0, r_m2}));
    r_n2  <= r_n1;
    r_cz2 <= r_cz1;
  end

  // Rounding constant 2^(n-1), absent when no shift is requested.
  always_comb begin
    w_s   = ACC_W'(r_p1) + ACC_W'(r_p2);
    w_rnd = '0;
    if (r_n2 != '0)
      w_rnd = RND_W'(1) << (r_n2 - N_W'(1));
  end

  // Stage 3: accumulate and add the rounding constant in the wide domain.
  always_ff @(posedge clk) begin
    r_sum <= RND_W'(w_s) + w_rnd;
    r_n3  <= r_n2;
    r_cz3 <= r_cz2;
  end

  // Arithmetic shift floors toward minus infinity, then apply zero point.
  always_comb begin
    w_t = r_sum >>> r_n3;
    w_z = w_t + $signed({{(RND_W-Y_W){1'b0}}, r_cz3});
  end

  // Stage 4: saturate; hold the last result while no new one is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_y <= '0;
    else if (i_out_en)
      r_y <= sat_u8(w_z);
  end

  assign o_y = r_y;

endmodule

// File: rtl/add_ppu_array.sv
// LANES-wide add PPU: pairs A/B beats and emits one clamped int8 result per lane per B beat.
// Latency: B beat at cycle t -> ppus_out_vld at t+4+PIPE_OUT.
// Backpressure: none; accepts a valid beat every cycle, outputs hold when not valid.
module add_ppu_array
  import add_ppu_array_pkg::*;
#(
  parameter int LANES    = 128,
  parameter int PIPE_OUT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*X_W-1:0]   ppus_Xs,
  input  logic                   ppus_Xs_vld,
  input  logic                   ppus_Xs_last,
  input  logic [M_W-1:0]         ppus_m1,
  input  logic [M_W-1:0]         ppus_m2,
  input  logic [N_W-1:0]         ppus_n,
  input  logic [Y_W-1:0]         ppus_Cz,
  output logic [LANES*Y_W-1:0]   ppus_outs,
  output logic                   ppus_out_vld,
  output logic                   ppus_out_last,
  output logic                   err_pulse
);

  phase_e                  r_phase, w_phase_nxt;
  logic                    w_a_ld, w_b_beat, w_err;
  logic [BASE_DEPTH-1:0]   r_vld, r_last;
  logic                    r_err;
  logic [LANES*Y_W-1:0]    w_y;

  // Phase register: A/B alternation, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_phase <= PH_A;
    else
      r_phase <= w_phase_nxt;
  end

  // Beat classification and next phase; a last beat always returns to A.
  always_comb begin
    w_phase_nxt = r_phase;
    w_a_ld      = 1'b0;
    w_b_beat    = 1'b0;
    w_err       = 1'b0;
    if (ppus_Xs_vld) begin
      if (r_phase == PH_A) begin
        w_a_ld = 1'b1;
        w_err  = ppus_Xs_last;
      end else begin
        w_b_beat = 1'b1;
      end
      if (ppus_Xs_last)
        w_phase_nxt = PH_A;
      else
        w_phase_nxt = (r_phase == PH_A) ? PH_B : PH_A;
    end
  end

  // Valid/last shadow the lane pipeline; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_last <= '0;
      r_err  <= 1'b0;
    end else begin
      r_vld  <= {r_vld[BASE_DEPTH-2:0], w_b_beat};
      r_last <= {r_last[BASE_DEPTH-2:0], w_b_beat & ppus_Xs_last};
      r_err  <= w_err;
    end
  end

  assign err_pulse = r_err;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    add_ppu_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_a_ld   (w_a_ld),
      .i_out_en (r_vld[BASE_DEPTH-2]),
      .i_x      (ppus_Xs[X_W*g +: X_W]),
      .i_m1     (ppus_m1),
      .i_m2     (ppus_m2),
      .i_n      (ppus_n),
      .i_cz     (ppus_Cz),
      .o_y      (w_y[Y_W*g +: Y_W])
    );
  end

  if (PIPE_OUT != 0) begin : g_pipe_out
    logic [LANES*Y_W-1:0] r_outs;
    logic                 r_out_vld, r_out_last;

    // Optional retiming stage; data only moves with a valid result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_outs     <= '0;
        r_out_vld  <= 1'b0;
        r_out_last <= 1'b0;
      end else begin
        r_out_vld  <= r_vld[BASE_DEPTH-1];
        r_out_last <= r_last[BASE_DEPTH-1];
        if (r_vld[BASE_DEPTH-1])
          r_outs <= w_y;
      end
    end

    assign ppus_outs     = r_outs;
    assign ppus_out_vld  = r_out_vld;
    assign ppus_out_last = r_out_last;
  end else begin : g_no_pipe_out
    assign ppus_outs     = w_y;
    assign ppus_out_vld  = r_vld[BASE_DEPTH-1];
    assign ppus_out_last = r_last[BASE_DEPTH-1];
  end

endmodule

// File: tb/tb_add_ppu_array.sv
// Randomized and directed bench for add_ppu_array against an arithmetic reference.
// Latency: expects results t+4+PIPE_OUT after each B beat.
// Backpressure: none; beats are driven every cycle or left idle at random.
module tb_add_ppu_array;

  localparam int L  = 8;
  localparam int PO = 0;
  localparam int LAT = 4 + PO;

  logic              clk = 1'b0;
  logic              rst;
  logic [L*9-1:0]    xs;
  logic              vld, last;
  logic [25:0]       m1, m2;
  logic [5:0]        n;
  logic [7:0]        cz;
  logic [L*8-1:0]    outs;
  logic              out_vld, out_last, err;

  add_ppu_array #(.LANES(L), .PIPE_OUT(PO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ppus_Xs      (xs),
    .ppus_Xs_vld  (vld),
    .ppus_Xs_last (last),
    .ppus_m1      (m1),
    .ppus_m2      (m2),
    .ppus_n       (n),
    .ppus_Cz      (cz),
    .ppus_outs    (outs),
    .ppus_out_vld (out_vld),
    .ppus_out_last(out_last),
    .err_pulse    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int             due;
    logic [L*8-1:0] y;
    logic           last;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              e_cur;
  int                err_due = -1;
  bit                mdl_b = 1'b0;
  int                mdl_a[L];
  bit                due_now;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: exact floor((S + 2^(n-1)) / 2^n) computed with wide integer division.
  function automatic logic [7:0] ref_y(input int a, input int b, input logic [25:0] s1,
                                       input logic [25:0] s2, input logic [5:0] sh,
                                       input logic [7:0] zp);
    longint            lm1, lm2, s;
    logic signed [127:0] num, d, q, z;
    lm1 = s1;
    lm2 = s2;
    s   = a * lm1 + b * lm2;
    if (sh == 0) begin
      q = s;
    end else begin
      d   = 128'sd1 <<< sh;
      num = s + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0)
        q = q - 1;
    end
    z = q + $signed({1'b0, zp});
    if (z < 0)   return 8'd0;
    if (z > 255) return 8'd255;
    return z[7:0];
  endfunction

  function automatic logic [L*9-1:0] fill(input int v);
    logic [L*9-1:0] r;
    for (int i = 0; i < L; i++) r[9*i +: 9] = 9'(v);
    return r;
  endfunction

  function automatic logic [L*9-1:0] rand_x();
    logic [L*9-1:0] r;
    for (int i = 0; i < L; i++) r[9*i +: 9] = 9'($urandom);
    return r;
  endfunction

  // Drive one cycle of input and advance the reference model by the same beat.
  task automatic beat(input bit v, input bit l, input logic [L*9-1:0] x,
                      input logic [25:0] a_m1, input logic [25:0] a_m2,
                      input logic [5:0] a_n, input logic [7:0] a_cz);
    exp_t e;
    vld = v; last = l; xs = x; m1 = a_m1; m2 = a_m2; n = a_n; cz = a_cz;
    if (v) begin
      if (!mdl_b) begin
        for (int i = 0; i < L; i++) mdl_a[i] = $signed(x[9*i +: 9]);
        if (l) err_due = cyc + 1;
        else   mdl_b = 1'b1;
      end else begin
        e.due  = cyc + LAT;
        e.last = l;
        for (int i = 0; i < L; i++)
          e.y[8*i +: 8] = ref_y(mdl_a[i], $signed(x[9*i +: 9]), a_m1, a_m2, a_n, a_cz);
        exp_q.push_back(e);
        mdl_b = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      beat(1'b0, 1'($urandom), rand_x(), 26'($urandom), 26'($urandom), 6'($urandom), 8'($urandom));
  endtask

  // A then B as one instruction; A-beat scales are junk and must be ignored.
  task automatic pair(input logic [L*9-1:0] xa, input logic [L*9-1:0] xb,
                      input logic [25:0] a_m1, input logic [25:0] a_m2,
                      input logic [5:0] a_n, input logic [7:0] a_cz);
    beat(1'b1, 1'b0, xa, 26'($urandom), 26'($urandom), 6'($urandom), 8'($urandom));
    beat(1'b1, 1'b1, xb, a_m1, a_m2, a_n, a_cz);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    err_due = -1;
    mdl_b   = 1'b0;
    vld     = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_vld",  64'(out_vld),  64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_err",      64'(err),      64'd0);
    chk("rst_outs",     64'(outs),     64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle-accurate scoreboard: valid, data, last and error pulse every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_vld", 64'(out_vld), 64'(due_now));
      if (due_now) begin
        e_cur = exp_q.pop_front();
        chk("outs",     64'(outs),     64'(e_cur.y));
        chk("out_last", 64'(out_last), 64'(e_cur.last));
      end
      chk("err_pulse", 64'(err), 64'(err_due == cyc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vld = 1'b0; last = 1'b0; xs = '0;
    m1 = '0; m2 = '0; n = '0; cz = '0;
    #1;
    do_reset();
    idle(3);

    // Basic sum at 2^20 scale.
    pair(fill(10), fill(20), 26'(1 << 20), 26'(1 << 20), 6'd20, 8'd0);
    idle(6);
    // Low and high clamps.
    pair(fill(-128), fill(-128), 26'(1 << 25), 26'(1 << 25), 6'd20, 8'd128);
    pair(fill(255), fill(255), 26'(1 << 25), 26'(1 << 25), 6'd20, 8'd128);
    // Rounding corners, including no shift and very large shifts.
    pair(fill(3), fill(0), 26'd1, 26'($urandom), 6'd1, 8'd0);
    pair(fill(-3), fill(0), 26'd1, 26'($urandom), 6'd1, 8'd5);
    pair(fill(7), fill(0), 26'd1, 26'($urandom), 6'd0, 8'd0);
    pair(rand_x(), rand_x(), 26'($urandom), 26'($urandom), 6'd63, 8'($urandom));
    pair(rand_x(), rand_x(), 26'($urandom), 26'($urandom), 6'd37, 8'($urandom));
    idle(6);

    // Back-to-back 64-beat instruction, last only on the final B.
    for (int i = 0; i < 64; i++)
      beat(1'b1, i == 63, rand_x(), 26'($urandom), 26'($urandom),
           6'($urandom_range(22, 36)), 8'($urandom));
    idle(6);

    // Orphan A: five beats with last on the fifth, then a clean pair.
    for (int i = 0; i < 5; i++)
      beat(1'b1, i == 4, rand_x(), 26'($urandom), 26'($urandom),
           6'($urandom_range(22, 36)), 8'($urandom));
    pair(rand_x(), rand_x(), 26'($urandom), 26'($urandom), 6'($urandom_range(24, 34)), 8'($urandom));
    idle(6);

    // Reset between A and its B, then a fresh pair.
    beat(1'b1, 1'b0, rand_x(), 26'($urandom), 26'($urandom), 6'd28, 8'd7);
    do_reset();
    idle(6);
    pair(fill(100), fill(-50), 26'd3000, 26'd7000, 6'd10, 8'd77);
    idle(6);

    // Random gaps, random lasts, parameters churning on idle cycles.
    for (int i = 0; i < 300; i++)
      beat(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), rand_x(),
           26'($urandom), 26'($urandom), 6'($urandom_range(0, 40)), 8'($urandom));

    idle(1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/add_ppu_array.md
ADD_PPU_ARRAY -- requirements
Module: add_ppu_array

Interface
REQ-001 Parameter LANES, default 128 (S*R), number of parallel int8 lanes per beat.
REQ-002 Parameter PIPE_OUT, default 1, extra output register stage (0 or 1) for timing closure.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ppus_Xs  input  LANES*9  per-lane signed 9-bit zero-point-corrected operands; lane i at bits [9i+8:9i].
REQ-006 ppus_Xs_vld / ppus_Xs_last  input  1 each  beat valid; last beat of the instruction.
REQ-007 ppus_m1, ppus_m2  input  26 each  unsigned scale for A and B operands.
REQ-008 ppus_n  input  6  right-shift amount; ppus_Cz  input  8  unsigned output zero point.
REQ-009 ppus_outs  output  LANES*8  unsigned 8-bit results, same lane packing.
REQ-010 ppus_out_vld / ppus_out_last  output  1 each  result valid; last result of the instruction.
REQ-011 err_pulse  output  1  one-cycle flag: ppus_Xs_last arrived on an A beat.

Function
REQ-012 Input beats alternate A then B; a phase bit SHALL start at A, toggle on each valid beat, and return to A after any beat carrying ppus_Xs_last.
REQ-013 On an A beat the block SHALL hold all LANES A operands; on the following B beat it SHALL launch one result per lane.
REQ-014 No back-pressure: the block SHALL accept a valid beat every cycle; invalid cycles SHALL NOT change phase or stored A.
REQ-015 Per lane: S = A*m1 + B*m2, signed, at least 37 bits, m1/m2 zero-extended.
REQ-016 Rounding: if n==0, T=S; else T = floor((S + 2^(n-1)) / 2^n) with arithmetic shift, exact for n up to 63 (T saturates to 0 or -1 for large n).
REQ-017 Output: Y = clamp(T + Cz, 0, 255).
REQ-018 m1, m2, n, Cz SHALL be sampled together with the B beat and carried down the pipeline; changes mid-pipeline SHALL NOT affect in-flight results.
REQ-019 Latency: B beat valid at cycle t -> ppus_out_vld high at t+4+PIPE_OUT; exactly one output per B beat, in order.
REQ-020 ppus_out_last SHALL equal ppus_Xs_last of the originating B beat, aligned with its ppus_out_vld.
REQ-021 ppus_Xs_last on an A beat: err_pulse high one cycle later, phase returns to A, no output produced for the orphan A.
REQ-022 ppus_outs value when ppus_out_vld low is don't-care but SHALL be deterministic (hold).

Reset
REQ-023 While rst high: phase=A, all valid/last pipeline bits, ppus_out_vld, ppus_out_last, err_pulse = 0; ppus_outs = 0.
REQ-024 Reset asserted mid-instruction SHALL discard all in-flight results; no vld pulse SHALL emerge after release until a new A/B pair is accepted.
REQ-025 Datapath registers other than valid/last/phase MAY be non-reset for DSP inference.

Structure
REQ-026 Shared package holds: lane operand width 9, output width 8, scale width 26, shift width 6, accumulator width 37, base pipeline depth 4.
REQ-027 One sub-module, add_ppu_lane, implements REQ-015..017 for one lane with a LANES-wide generate in the top; control (phase, valid/last, err) lives only in the top.
REQ-028 Multiplies SHALL map to DSP slices with pipeline registers inside add_ppu_lane.

Verification
REQ-029 A=10, B=20, m1=m2=2^20, n=20, Cz=0 all lanes -> Y=30, vld at t+4 (PIPE_OUT=0).
REQ-030 A=-128, B=-128, m1=m2=2^25, n=20, Cz=128 -> T=-8192, Y=0 (low clamp); A=B=255, same scales, Cz=128 -> Y=255 (high clamp).
REQ-031 Rounding: A=3, B=0, m1=1, n=1, Cz=0 -> Y=2; A=-3 -> T=-1, Cz=5 -> Y=4; n=0, A=7,m1=1 -> Y=7.
REQ-032 Back-to-back 64-beat stream (32 pairs), random lanes, last on beat 64 -> 32 outputs matching model, ppus_out_last only on 32nd, no gaps.
REQ-033 Stream of 5 beats with last on beat 5 -> 2 outputs, err_pulse once, next pair processed correctly.
REQ-034 rst pulsed between an A and its B beat -> no output; subsequent fresh pair produces correct single output.
